// File: rtl/fpmult_prep_seq.sv
// Floating-point multiplier front end: unpacks and classifies two operands, then forms
// the full significand product with an iterative radix-2^DIGIT_W multiplier.
module fpmult_prep_seq #(
   parameter int EXP_W   = 8,
   parameter int MAN_W   = 23,
   parameter int DIGIT_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   Sa,
   output logic                   Sb,
   output logic [EXP_W-1:0]       Ea,
   output logic [EXP_W-1:0]       Eb,
   output logic [2*MAN_W+1:0]     Mp,
   output logic [6:0]             InputExc
);

   localparam int SIG_W = MAN_W + 1;
   localparam int PW    = 2 * SIG_W;
   localparam int NCYC  = (SIG_W + DIGIT_W - 1) / DIGIT_W;
   localparam int BW    = NCYC * DIGIT_W;
   localparam int CW    = (NCYC > 1) ? $clog2(NCYC) : 1;

   typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

   state_t            state_reg;
   logic [PW-1:0]     mcand_reg;
   logic [BW-1:0]     mplier_reg;
   logic [PW-1:0]     acc_reg;
   logic [CW-1:0]     cnt_reg;

   logic [EXP_W-1:0]  exp_a, exp_b;
   logic [MAN_W-1:0]  frac_a, frac_b;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [6:0]        exc_in;
   logic [SIG_W-1:0]  sig_a_in, sig_b_in;
   logic              skip_mult;

   logic [PW-1:0]     pp_term [DIGIT_W];
   logic [PW-1:0]     digit_prod;
   logic [PW-1:0]     acc_next;

   assign exp_a  = a[EXP_W+MAN_W-1:MAN_W];
   assign exp_b  = b[EXP_W+MAN_W-1:MAN_W];
   assign frac_a = a[MAN_W-1:0];
   assign frac_b = b[MAN_W-1:0];

   assign a_nan  = (&exp_a) & (|frac_a);
   assign b_nan  = (&exp_b) & (|frac_b);
   assign a_inf  = (&exp_a) & ~(|frac_a);
   assign b_inf  = (&exp_b) & ~(|frac_b);
   assign a_zero = ~(|exp_a) & ~(|frac_a);
   assign b_zero = ~(|exp_b) & ~(|frac_b);

   assign exc_in    = {a_zero, b_zero, (a_nan | b_nan | a_inf | b_inf), a_nan, b_nan, a_inf, b_inf};
   assign skip_mult = exc_in[6] | exc_in[5] | exc_in[4];

   // Denormals keep a 0 hidden bit and are multiplied as-is.
   assign sig_a_in = {|exp_a, frac_a};
   assign sig_b_in = {|exp_b, frac_b};

   assign in_ready = (state_reg == IDLE);

   // The multiplicand is pre-shifted each cycle, so digit bit gi weighs mcand << gi.
   generate
      for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_pp
         assign pp_term[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
      end
   endgenerate

   always_comb begin
      digit_prod = '0;
      for (int i = 0; i < DIGIT_W; i++) begin
         digit_prod = digit_prod + pp_term[i];
      end
   end

   assign acc_next = acc_reg + digit_prod;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         out_valid  <= 1'b0;
         Sa         <= 1'b0;
         Sb         <= 1'b0;
         Ea         <= '0;
         Eb         <= '0;
         Mp         <= '0;
         InputExc   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  Sa         <= a[EXP_W+MAN_W];
                  Sb         <= b[EXP_W+MAN_W];
                  Ea         <= exp_a;
                  Eb         <= exp_b;
                  InputExc   <= exc_in;
                  Mp         <= '0;
                  mcand_reg  <= PW'(sig_a_in);
                  mplier_reg <= BW'(sig_b_in);
                  acc_reg    <= '0;
                  cnt_reg    <= '0;
                  if (skip_mult) begin
                     out_valid <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     state_reg <= MULT;
                  end
               end
            end
            MULT: begin
               acc_reg    <= acc_next;
               mcand_reg  <= mcand_reg << DIGIT_W;
               mplier_reg <= mplier_reg >> DIGIT_W;
               cnt_reg    <= cnt_reg + CW'(1);
               if (cnt_reg == CW'(NCYC - 1)) begin
                  Mp        <= acc_next;
                  out_valid <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpmult_prep_seq.sv
// Bench for fpmult_prep_seq: vector table and random operands against a scoreboard, run on
// a DIGIT_W=4 and a DIGIT_W=5 instance in lockstep, plus backpressure and mid-operation reset.
module tb_fpmult_prep_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;

   logic        in_ready, out_valid, Sa, Sb;
   logic [7:0]  Ea, Eb;
   logic [47:0] Mp;
   logic [6:0]  InputExc;

   logic        in_ready5, out_valid5, Sa5, Sb5;
   logic [7:0]  Ea5, Eb5;
   logic [47:0] Mp5;
   logic [6:0]  InputExc5;

   always #5 clk = ~clk;

   fpmult_prep_seq #(.EXP_W(8), .MAN_W(23), .DIGIT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .Sa(Sa), .Sb(Sb), .Ea(Ea), .Eb(Eb),
      .Mp(Mp), .InputExc(InputExc)
   );

   fpmult_prep_seq #(.EXP_W(8), .MAN_W(23), .DIGIT_W(5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5), .a(a), .b(b),
      .out_valid(out_valid5), .out_ready(out_ready), .Sa(Sa5), .Sb(Sb5), .Ea(Ea5), .Eb(Eb5),
      .Mp(Mp5), .InputExc(InputExc5)
   );

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        sa;
      logic        sb;
      logic [7:0]  ea;
      logic [7:0]  eb;
      logic [47:0] mp;
      logic [6:0]  exc;
      int          lat;
   } vec_t;

   vec_t vecs[5];
   vec_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [31:0] va, input logic [31:0] vb,
                               input logic sa, input logic sb, input logic [7:0] ea,
                               input logic [7:0] eb, input logic [47:0] mp,
                               input logic [6:0] exc, input int lat);
      vec_t v;
      v.name = name; v.a = va; v.b = vb; v.sa = sa; v.sb = sb;
      v.ea = ea; v.eb = eb; v.mp = mp; v.exc = exc; v.lat = lat;
      return v;
   endfunction

   // Reference: plain classification and a single full-width product.
   function automatic vec_t model(input string name, input logic [31:0] va, input logic [31:0] vb);
      vec_t        v;
      logic [7:0]  xa, xb;
      logic [22:0] fa, fb;
      logic        an, bn, ai, bi, az, bz;
      logic [47:0] siga, sigb;
      xa = va[30:23]; xb = vb[30:23]; fa = va[22:0]; fb = vb[22:0];
      an = (xa == 8'hFF) && (fa != 0);
      bn = (xb == 8'hFF) && (fb != 0);
      ai = (xa == 8'hFF) && (fa == 0);
      bi = (xb == 8'hFF) && (fb == 0);
      az = (xa == 8'h00) && (fa == 0);
      bz = (xb == 8'h00) && (fb == 0);
      siga = {24'd0, (xa != 0), fa};
      sigb = {24'd0, (xb != 0), fb};
      v.name = name; v.a = va; v.b = vb; v.sa = va[31]; v.sb = vb[31]; v.ea = xa; v.eb = xb;
      v.exc = {az, bz, (an | bn | ai | bi), an, bn, ai, bi};
      if (an | bn | ai | bi | az | bz) begin
         v.mp  = '0;
         v.lat = 1;
      end else begin
         v.mp  = siga * sigb;
         v.lat = 6;
      end
      return v;
   endfunction

   // hold: cycles of backpressure before release, with stray in_valid during the hold.
   task automatic run_op(input vec_t v, input int hold);
      vec_t e;
      int   g, lat4, lat5, lat5_req;
      g = 0;
      @(negedge clk);
      while (!(in_ready && in_ready5) && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) check("accept_wait", 64'd0, 64'd1);
      a = v.a; b = v.b; in_valid = 1'b1;
      sbq.push_back(v);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat4 = -1; lat5 = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (out_valid && lat4 < 0) lat4 = n;
         if (out_valid5 && lat5 < 0) lat5 = n;
         if (lat4 >= 0 && lat5 >= 0) break;
      end
      e = sbq.pop_front();
      lat5_req = (e.lat == 1) ? 1 : 5;
      check({e.name, " lat"},  64'(lat4), 64'(e.lat));
      check({e.name, " lat5"}, 64'(lat5), 64'(lat5_req));
      check({e.name, " Sa"},   64'(Sa), 64'(e.sa));
      check({e.name, " Sb"},   64'(Sb), 64'(e.sb));
      check({e.name, " Ea"},   64'(Ea), 64'(e.ea));
      check({e.name, " Eb"},   64'(Eb), 64'(e.eb));
      check({e.name, " Mp"},   64'(Mp), 64'(e.mp));
      check({e.name, " exc"},  64'(InputExc), 64'(e.exc));
      check({e.name, " Mp5"},  64'(Mp5), 64'(e.mp));
      check({e.name, " exc5"}, 64'(InputExc5), 64'(e.exc));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         a = $urandom; b = $urandom; in_valid = 1'b1;
         @(posedge clk);
         #1;
         check({e.name, " hold valid"}, 64'(out_valid), 64'd1);
         check({e.name, " hold ready"}, 64'(in_ready), 64'd0);
         check({e.name, " hold Mp"},    64'(Mp), 64'(e.mp));
         check({e.name, " hold Ea"},    64'(Ea), 64'(e.ea));
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({e.name, " release valid"},  64'(out_valid), 64'd0);
      check({e.name, " release valid5"}, 64'(out_valid5), 64'd0);
      check({e.name, " release ready"},  64'(in_ready), 64'd1);
      if (hold > 0) begin
         repeat (3) @(posedge clk);
         #1 check({e.name, " no stray op"}, 64'(out_valid), 64'd0);
      end
      $display("op %s: a=%h b=%h Mp=%h exc=%h lat=%0d lat5=%0d", e.name, e.a, e.b, Mp5, InputExc, lat4, lat5);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t r;
      vecs[0] = mk("1x2",     32'h3F800000, 32'h40000000, 1'b0, 1'b0, 8'h7F, 8'h80, 48'h4000_0000_0000, 7'h00, 6);
      vecs[1] = mk("1.5x-1.5",32'h3FC00000, 32'hBFC00000, 1'b0, 1'b1, 8'h7F, 8'h7F, 48'h9000_0000_0000, 7'h00, 6);
      vecs[2] = mk("nan",     32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 8'hFF, 8'h7F, 48'h0,              7'h18, 1);
      vecs[3] = mk("infx0",   32'h7F800000, 32'h00000000, 1'b0, 1'b0, 8'hFF, 8'h00, 48'h0,              7'h32, 1);
      vecs[4] = mk("denorm",  32'h00400000, 32'h3F800000, 1'b0, 1'b0, 8'h00, 8'h7F, 48'h2000_0000_0000, 7'h00, 6);

      #12;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset in_ready",  64'(in_ready),  64'd1);
      check("reset Mp",        64'(Mp),        64'd0);
      check("reset exc",       64'(InputExc),  64'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 5; i++) run_op(vecs[i], 0);

      for (int i = 0; i < 6; i++) begin
         logic [31:0] ra, rb;
         ra = {$urandom_range(1), 8'($urandom_range(254, 1)), 23'($urandom)};
         rb = {$urandom_range(1), 8'($urandom_range(254, 1)), 23'($urandom)};
         if (i == 5) rb[30:23] = 8'h00;
         r = model($sformatf("rand%0d", i), ra, rb);
         run_op(r, 0);
      end

      run_op(vecs[1], 10);

      // Reset during MULT digit k=3: operation is dropped, outputs clear without a clock edge.
      @(negedge clk);
      a = 32'h3FC00000; b = 32'hBFC00000; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("pre-reset Sb", 64'(Sb), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("async rst out_valid", 64'(out_valid), 64'd0);
      check("async rst Sb",        64'(Sb),        64'd0);
      check("async rst Ea",        64'(Ea),        64'd0);
      check("async rst Mp",        64'(Mp),        64'd0);
      check("async rst in_ready",  64'(in_ready),  64'd1);
      check("async rst Ea5",       64'(Ea5),       64'd0);
      $display("op reset-mid-mult: Sb=%0d Ea=%h in_ready=%0d", Sb, Ea, in_ready);
      @(negedge clk);
      rst = 1'b1;
      repeat (8) @(posedge clk);
      #1 check("post-reset no output", 64'(out_valid), 64'd0);
      run_op(vecs[0], 0);

      check("scoreboard empty", 64'(sbq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
